uc_multiciclo: RTL and testbench

Multicycle sequencer for the CPU datapath (PC, instruction memory, register file, ALU, Z flag). Steps each instruction through FETCH/DECODE/EXEC and drives PC-mux, immediate-mux, register-file and flag write enables.
Adds an instruction-memory request/acknowledge handshake, a fetch timeout with a sticky error, run/stop control and a retired-instruction counter. The datapath's IR feeds opcode back to this block.

---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/uc_decode.sv | 39 +++
 rtl/uc_multiciclo.sv | 116 +++++++++++
 tb/tb_uc_multiciclo.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: FSM states, opcode classes and the
// opcode classification patterns used by the multicycle sequencer.
package cpu_pkg;

  localparam int OPCODE_W = 6;
  localparam int OP_ALU_W = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_ERROR
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LDI,
    CL_JMP,
    CL_JZ,
    CL_JNZ
  } op_class_t;

  localparam logic [OPCODE_W-1:0] PAT_ALU = 6'b0?????;
  localparam logic [OPCODE_W-1:0] PAT_LDI = 6'b10????;
  localparam logic [OPCODE_W-1:0] PAT_JMP = 6'b110???;
  localparam logic [OPCODE_W-1:0] PAT_JZ  = 6'b1110??;
  localparam logic [OPCODE_W-1:0] PAT_JNZ = 6'b1111??;

  // Every opcode falls into exactly one class, so there is no illegal opcode.
  function automatic op_class_t classify(input logic [OPCODE_W-1:0] opcode);
    op_class_t c;
    c = CL_ALU;
    casez (opcode)
      PAT_ALU: c = CL_ALU;
      PAT_LDI: c = CL_LDI;
      PAT_JMP: c = CL_JMP;
      PAT_JZ:  c = CL_JZ;
      PAT_JNZ: c = CL_JNZ;
      default: c = CL_ALU;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uc_decode.sv
// Combinational execute-stage control decode: instruction class, ALU field
// and Z flag to PC-mux, immediate-mux and write enables.
module uc_decode
  import cpu_pkg::*;
(
  input  op_class_t            op_class,
  input  logic [OP_ALU_W-1:0]  alu_field,
  input  logic                 z,
  output logic                 s_inc,
  output logic                 s_inm,
  output logic                 we3,
  output logic                 wez,
  output logic [OP_ALU_W-1:0]  op_alu
);

  always_comb begin
    s_inc  = 1'b1;
    s_inm  = 1'b0;
    we3    = 1'b0;
    wez    = 1'b0;
    op_alu = '0;
    case (op_class)
      CL_ALU: begin
        op_alu = alu_field;
        we3    = 1'b1;
        wez    = 1'b1;
      end
      CL_LDI: begin
        we3   = 1'b1;
        s_inm = 1'b1;
      end
      CL_JMP:  s_inc = 1'b0;
      CL_JZ:   s_inc = ~z;
      CL_JNZ:  s_inc = z;
      default: s_inc = 1'b1;
    endcase
  end

endmodule

// File: rtl/uc_multiciclo.sv
// Multicycle control unit: FETCH/DECODE/EXEC sequencing with an instruction
// memory handshake, fetch timeout into a sticky ERROR state and a retired count.
module uc_multiciclo
  import cpu_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CW            = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [OPCODE_W-1:0]  opcode,
  input  logic                 z,
  input  logic                 imem_ack,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic                 s_inc,
  output logic                 s_inm,
  output logic                 we3,
  output logic                 wez,
  output logic [OP_ALU_W-1:0]  op_alu,
  output logic                 busy,
  output logic                 err,
  output logic [CW-1:0]        instr_count
);

  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  // Counter value seen in the last FETCH cycle before a timeout.
  localparam logic [TW-1:0] TO_LAST = TW'(FETCH_TIMEOUT - 1);

  state_t    state, state_next;
  op_class_t op_class_q;
  logic [TW-1:0] to_cnt;

  logic                dec_s_inc, dec_s_inm, dec_we3, dec_wez;
  logic [OP_ALU_W-1:0] dec_op_alu;

  uc_decode u_decode (
    .op_class  (op_class_q),
    .alu_field (opcode[4:2]),
    .z         (z),
    .s_inc     (dec_s_inc),
    .s_inm     (dec_s_inm),
    .we3       (dec_we3),
    .wez       (dec_wez),
    .op_alu    (dec_op_alu)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (run) state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)              state_next = ST_DECODE;
        else if (to_cnt == TO_LAST) state_next = ST_ERROR;
      end
      ST_DECODE: state_next = ST_EXEC;
      ST_EXEC:   state_next = run ? ST_FETCH : ST_IDLE;
      ST_ERROR:  state_next = ST_ERROR;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Class is captured in DECODE so EXEC controls do not depend on decode timing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt      <= '0;
      op_class_q  <= CL_ALU;
      instr_count <= '0;
    end else begin
      if (state == ST_FETCH && !imem_ack) to_cnt <= to_cnt + TW'(1);
      else                                to_cnt <= '0;
      if (state == ST_DECODE) op_class_q <= classify(opcode);
      if (state == ST_EXEC)   instr_count <= instr_count + CW'(1);
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    we3      = 1'b0;
    wez      = 1'b0;
    op_alu   = '0;
    busy     = 1'b0;
    err      = 1'b0;
    case (state)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ack;
        busy     = 1'b1;
      end
      ST_DECODE: busy = 1'b1;
      ST_EXEC: begin
        busy   = 1'b1;
        pc_we  = 1'b1;
        s_inc  = dec_s_inc;
        s_inm  = dec_s_inm;
        we3    = dec_we3;
        wez    = dec_wez;
        op_alu = dec_op_alu;
      end
      ST_ERROR: err = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uc_multiciclo.sv
// Self-checking bench for uc_multiciclo: directed instruction sequences plus
// randomized instructions compared against an instruction-level model.
module tb_uc_multiciclo;

  localparam int TO_TB = 4;
  localparam int CW_TB = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              run;
  logic [5:0]        opcode;
  logic              z;
  logic              imem_ack;
  logic              imem_req, ir_we, pc_we, s_inc, s_inm, we3, wez;
  logic [2:0]        op_alu;
  logic              busy, err;
  logic [CW_TB-1:0]  instr_count;

  int checks = 0;
  int failures = 0;
  int model_count = 0;

  uc_multiciclo #(.FETCH_TIMEOUT(TO_TB), .CW(CW_TB)) dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .opcode      (opcode),
    .z           (z),
    .imem_ack    (imem_ack),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .pc_we       (pc_we),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we3         (we3),
    .wez         (wez),
    .op_alu      (op_alu),
    .busy        (busy),
    .err         (err),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Instruction-level reference: what EXEC must drive for a given opcode and Z.
  task automatic expectExec(input logic [5:0] op, input logic zval,
                            output logic e_inc, output logic e_inm,
                            output logic e_we3, output logic e_wez,
                            output logic [2:0] e_alu);
    e_inc = 1'b1; e_inm = 1'b0; e_we3 = 1'b0; e_wez = 1'b0; e_alu = 3'd0;
    if (!op[5]) begin
      e_alu = op[4:2]; e_we3 = 1'b1; e_wez = 1'b1;
    end else if (!op[4]) begin
      e_we3 = 1'b1; e_inm = 1'b1;
    end else if (!op[3]) e_inc = 1'b0;
    else if (!op[2])     e_inc = ~zval;
    else                 e_inc = zval;
  endtask

  // Runs one instruction starting from a FETCH cycle; waits = cycles before ack.
  task automatic applyStimulus(input logic [5:0] op, input int waits,
                               input logic zval, input logic run_next);
    logic e_inc, e_inm, e_we3, e_wez;
    logic [2:0] e_alu;
    for (int w = 0; w <= waits; w++) begin
      @(negedge clk);
      imem_ack = (w == waits);
      opcode   = 6'($urandom);
      z        = 1'($urandom);
      #1;
      checkOutput("fetch_req", imem_req, 1);
      checkOutput("fetch_ir_we", ir_we, (w == waits));
      checkOutput("fetch_busy", busy, 1);
      checkOutput("fetch_pc_we", pc_we, 0);
      checkOutput("fetch_we3", we3, 0);
      checkOutput("fetch_count", instr_count, model_count);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    opcode   = op;
    z        = ~zval;
    run      = run_next;
    #1;
    checkOutput("decode_req", imem_req, 0);
    checkOutput("decode_ir_we", ir_we, 0);
    checkOutput("decode_pc_we", pc_we, 0);
    checkOutput("decode_we3", we3, 0);
    checkOutput("decode_wez", wez, 0);
    checkOutput("decode_busy", busy, 1);
    checkOutput("decode_err", err, 0);
    @(negedge clk);
    z = zval;
    #1;
    expectExec(op, zval, e_inc, e_inm, e_we3, e_wez, e_alu);
    checkOutput("exec_pc_we", pc_we, 1);
    checkOutput("exec_s_inc", s_inc, e_inc);
    checkOutput("exec_s_inm", s_inm, e_inm);
    checkOutput("exec_we3", we3, e_we3);
    checkOutput("exec_wez", wez, e_wez);
    checkOutput("exec_op_alu", op_alu, e_alu);
    checkOutput("exec_req", imem_req, 0);
    checkOutput("exec_count", instr_count, model_count);
    model_count = (model_count + 1) % (1 << CW_TB);
    if (!run_next) begin
      @(negedge clk);
      #1;
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_req", imem_req, 0);
      checkOutput("idle_pc_we", pc_we, 0);
      checkOutput("idle_count", instr_count, model_count);
      run = 1'b1;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0;
    #1;
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_count", instr_count, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    model_count = 0;
  endtask

  initial begin
    reset = 1'b0; run = 1'b0; opcode = '0; z = 1'b0; imem_ack = 1'b0;
    #1;
    checkOutput("reset_s_inc", s_inc, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_count", instr_count, 0);
    checkOutput("reset_req", imem_req, 0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      checkOutput("idle_hold_busy", busy, 0);
      checkOutput("idle_hold_req", imem_req, 0);
    end
    run = 1'b1;

    applyStimulus(6'b001100, 0, 1'b0, 1'b1);
    applyStimulus(6'b100000, 2, 1'b1, 1'b1);
    applyStimulus(6'b111000, 0, 1'b1, 1'b1);
    applyStimulus(6'b111000, 1, 1'b0, 1'b1);
    applyStimulus(6'b111100, 0, 1'b0, 1'b1);
    applyStimulus(6'b111100, 0, 1'b1, 1'b1);
    applyStimulus(6'b110101, 1, 1'b1, 1'b1);
    applyStimulus(6'($urandom), TO_TB - 1, 1'($urandom), 1'b1);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(6'($urandom), int'($urandom_range(0, TO_TB - 1)), 1'($urandom),
                    (i == 23) ? 1'b1 : ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while a fetch is outstanding.
    @(negedge clk);
    imem_ack = 1'b0;
    #1;
    checkOutput("midfetch_req_before", imem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midfetch_req", imem_req, 0);
    checkOutput("midfetch_s_inc", s_inc, 1);
    checkOutput("midfetch_count", instr_count, 0);
    checkOutput("midfetch_err", err, 0);
    checkOutput("midfetch_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1; run = 1'b0;
    model_count = 0;

    // Counter wrap with run dropped during the fourth instruction's DECODE.
    @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(6'($urandom), 0, 1'($urandom), 1'b1);
    applyStimulus(6'b000100, 0, 1'b0, 1'b0);
    checkOutput("wrap_zero", instr_count, 0);
    applyStimulus(6'b101010, 0, 1'b0, 1'b0);

    // Fetch timeout into the sticky error state.
    doReset();
    @(negedge clk);
    run = 1'b1;
    for (int w = 0; w < TO_TB; w++) begin
      @(negedge clk);
      imem_ack = 1'b0;
      #1;
      checkOutput("to_fetch_req", imem_req, 1);
      checkOutput("to_fetch_err", err, 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      imem_ack = 1'($urandom);
      #1;
      checkOutput("to_err", err, 1);
      checkOutput("to_busy", busy, 0);
      checkOutput("to_req", imem_req, 0);
      checkOutput("to_ir_we", ir_we, 0);
      checkOutput("to_pc_we", pc_we, 0);
    end
    doReset();
    checkOutput("to_cleared_err", err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
